axi_slave_burst_ps: RTL and testbench
=====================================

// Module: axi_slave_burst_ps
// PURPOSE
//  Parametrised AXI3/4 slave front-end for streaming DSP cores (FFT and successors); replaces the single-beat PS wrapper.
//  Full INCR bursts (1-256 beats), queued outstanding AW/AR commands, core backpressure, and an in-band clear
//  word that produces a registered core_clr pulse instead of gating reset. PS writes samples, reads results.
// PARAMETERS
//  WIDTH_SID  15  AXI ID width
//  WIDTH_AD   14  address width (address ignored, single stream port)
//  WIDTH_DA   32  data width; core_in/out data width
//  WIDTH_DS    4  strobe width (WIDTH_DA/8); WSTRB ignored, full-word writes only
//  CMD_AW      2  log2 depth of AW and AR command FIFOs (4 outstanding each)
//  CLR_WORD   32'h7FFFFFFF  write data value interpreted as core clear
// PORTS
//  S_AXI_ACLK      in   1          clock, all logic rising edge
//  S_AXI_ARESET    in   1          reset, asynchronous, active-high
//  S_AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  in  SID/AD/8/3/2/1    write address channel
//  S_AXI_AWREADY   out  1          AW FIFO not full
//  S_AXI_W{DATA,STRB,LAST,VALID}  in  DA/DS/1/1   write data channel
//  S_AXI_WREADY    out  1          write beat accepted
//  S_AXI_B{ID,RESP,VALID}  out  SID/2/1   write response; S_AXI_BREADY in 1
//  S_AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID}  in  SID/AD/8/3/2/1    read address channel
//  S_AXI_ARREADY   out  1          AR FIFO not full
//  S_AXI_R{ID,DATA,RESP,LAST,VALID}  out  SID/DA/2/1/1   read data; S_AXI_RREADY in 1
//  core_clr        out  1          one-cycle clear pulse to core
//  core_in_data/valid   out  DA/1  sample stream to core; core_in_ready in 1
//  core_out_data/valid  in   DA/1  result stream from core; core_out_ready out 1
// BEHAVIOUR
//  Reset: all outputs 0, both FIFOs empty, R FSM IDLE; AWREADY/ARREADY rise 1 cycle after ARESET falls. Reset mid-burst discards all state.
//  AW: push {AWID, err=(AWBURST!=2'b01)} on AWVALID&&AWREADY; LEN/SIZE/ADDR not stored.
//  W: wr_ok = AW FIFO non-empty && (!BVALID || BREADY). WREADY = wr_ok && (core_in_ready || WDATA==CLR_WORD || head.err).
//   Beat with WDATA==CLR_WORD: not forwarded; core_clr=1 next cycle for exactly one cycle.
//   Other beats of non-err burst: core_in_valid = WVALID && wr_ok (combinational), core_in_data = WDATA. err bursts drain, never forwarded.
//   WLAST accepted: pop AW FIFO same cycle; next cycle BVALID=1, BID=head.id, BRESP = err ? 2'b10 : 2'b00.
//   BVALID holds until BREADY; the wr_ok gate guarantees at most one pending B. Beat count vs AWLEN not checked (WLAST authoritative).
//  AR: push {ARID, ARLEN, err=(ARBURST!=2'b01)}.
//  R FSM: IDLE -> BURST when AR FIFO non-empty (pop, load id/len/err, cnt=0; 1 cycle). BURST -> IDLE on last beat handshake.
//   BURST, !err: RVALID = core_out_valid, RDATA = core_out_data, core_out_ready = RREADY, RRESP=00.
//   BURST, err: RVALID=1, RDATA=0, RRESP=2'b10, core_out_ready=0.
//   RLAST = (cnt==len) while BURST; cnt increments on RVALID&&RREADY; RID = latched id.
//   Back-to-back bursts: one IDLE bubble between bursts (min 1 cycle).
//  Simultaneous push/pop on full FIFO: pop frees entry, push still refused that cycle (READY from registered full flag).
//  AW and AR paths fully independent; no ordering between reads and writes.
// STRUCTURE
//  Package axi_ps_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01, r_state_t {R_IDLE,R_BURST}.
//  Sub-module: axi_slave_fifo_sync (existing, parametrised DW/AW) instantiated twice: AW (DW=WIDTH_SID+1), AR (DW=WIDTH_SID+9);
//   reset adapted to async active-high.
// TESTING
//  1. AW id=3 len=7 INCR, 8 W beats with core_in_ready=1 -> 8 core_in beats, WREADY 8 cycles, BVALID id=3 resp=00 1 cycle after WLAST.
//  2. Same burst, core_in_ready toggled 1/0 -> WREADY follows ready, data order intact, no beat duplicated or lost.
//  3. Single beat WDATA=32'h7FFFFFFF -> core_clr high exactly 1 cycle, core_in_valid never high, BRESP=00.
//  4. AR id=5 len=3 INCR, core_out supplies 4 words, RREADY stalls beat 2 -> 4 beats id=5, RLAST only on 4th, RDATA stable while stalled.
//  5. AR with ARBURST=2'b10 len=1 -> 2 beats RDATA=0 RRESP=10, core_out_ready stays 0; AW WRAP -> BRESP=10, nothing forwarded.
//  6. Fill 4 AWs with BREADY=0, assert ARESET mid-burst -> all outputs 0 async, AWREADY=1 one cycle after release.

Source files
------------

// File: rtl/axi_ps_pkg.sv
// Shared constants and the read-channel state type for the AXI slave burst front-end.
package axi_ps_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_t;

endpackage

// File: rtl/axi_slave_fifo_sync.sv
// Show-ahead synchronous command FIFO, 2**AW entries deep.
// The push-side ready is registered, so a pop on a full FIFO frees a slot only for the next cycle.
module axi_slave_fifo_sync #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic          ready,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && ready_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign ready = ready_q;
    assign empty = empty_q;

endmodule

// File: rtl/axi_slave_burst_ps.sv
// AXI3/4 slave front-end for streaming DSP cores: INCR bursts into core_in, core_out into read bursts,
// queued AW/AR commands and an in-band clear word that raises a one-cycle core_clr.
module axi_slave_burst_ps
    import axi_ps_pkg::*;
#(
    parameter int unsigned         WIDTH_SID = 15,
    parameter int unsigned         WIDTH_AD  = 14,
    parameter int unsigned         WIDTH_DA  = 32,
    parameter int unsigned         WIDTH_DS  = 4,
    parameter int unsigned         CMD_AW    = 2,
    parameter logic [WIDTH_DA-1:0] CLR_WORD  = WIDTH_DA'(32'h7FFF_FFFF)
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESET,
    input  logic [WIDTH_SID-1:0] S_AXI_AWID,
    input  logic [WIDTH_AD-1:0]  S_AXI_AWADDR,
    input  logic [7:0]           S_AXI_AWLEN,
    input  logic [2:0]           S_AXI_AWSIZE,
    input  logic [1:0]           S_AXI_AWBURST,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [WIDTH_DA-1:0]  S_AXI_WDATA,
    input  logic [WIDTH_DS-1:0]  S_AXI_WSTRB,
    input  logic                 S_AXI_WLAST,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [WIDTH_SID-1:0] S_AXI_BID,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [WIDTH_SID-1:0] S_AXI_ARID,
    input  logic [WIDTH_AD-1:0]  S_AXI_ARADDR,
    input  logic [7:0]           S_AXI_ARLEN,
    input  logic [2:0]           S_AXI_ARSIZE,
    input  logic [1:0]           S_AXI_ARBURST,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [WIDTH_SID-1:0] S_AXI_RID,
    output logic [WIDTH_DA-1:0]  S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RLAST,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY,
    output logic                 core_clr,
    output logic [WIDTH_DA-1:0]  core_in_data,
    output logic                 core_in_valid,
    input  logic                 core_in_ready,
    input  logic [WIDTH_DA-1:0]  core_out_data,
    input  logic                 core_out_valid,
    output logic                 core_out_ready
);

    logic                 aw_empty, aw_pop, aw_head_err;
    logic [WIDTH_SID:0]   aw_dout;
    logic [WIDTH_SID-1:0] aw_head_id;
    logic                 ar_empty, ar_pop;
    logic [WIDTH_SID+8:0] ar_dout;

    logic                 wr_ok, is_clr, fwd, w_hs;
    logic                 clr_q, clr_d;
    logic                 bvalid_q, bvalid_d;
    logic [WIDTH_SID-1:0] bid_q, bid_d;
    logic [1:0]           bresp_q, bresp_d;

    r_state_t             state_q, state_d;
    logic [WIDTH_SID-1:0] rid_q, rid_d;
    logic [7:0]           rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic                 rerr_q, rerr_d;
    logic                 in_burst, r_hs;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_WSTRB,
                             S_AXI_ARADDR, S_AXI_ARSIZE};

    axi_slave_fifo_sync #(.DW(WIDTH_SID + 1), .AW(CMD_AW)) u_aw_fifo (
        .clk   (S_AXI_ACLK),
        .rst   (S_AXI_ARESET),
        .push  (S_AXI_AWVALID),
        .din   ({S_AXI_AWID, S_AXI_AWBURST != BURST_INCR}),
        .ready (S_AXI_AWREADY),
        .pop   (aw_pop),
        .dout  (aw_dout),
        .empty (aw_empty)
    );

    axi_slave_fifo_sync #(.DW(WIDTH_SID + 9), .AW(CMD_AW)) u_ar_fifo (
        .clk   (S_AXI_ACLK),
        .rst   (S_AXI_ARESET),
        .push  (S_AXI_ARVALID),
        .din   ({S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARBURST != BURST_INCR}),
        .ready (S_AXI_ARREADY),
        .pop   (ar_pop),
        .dout  (ar_dout),
        .empty (ar_empty)
    );

    assign aw_head_id  = aw_dout[WIDTH_SID:1];
    assign aw_head_err = aw_dout[0];

    // Write beats only flow while the single B slot is free or draining this cycle.
    always_comb begin
        wr_ok        = !aw_empty && (!bvalid_q || S_AXI_BREADY);
        is_clr       = (S_AXI_WDATA == CLR_WORD);
        S_AXI_WREADY = wr_ok && (core_in_ready || is_clr || aw_head_err);
        w_hs         = S_AXI_WVALID && S_AXI_WREADY;
        fwd          = S_AXI_WVALID && wr_ok && !is_clr && !aw_head_err;
        aw_pop       = w_hs && S_AXI_WLAST;
        clr_d        = w_hs && is_clr && !aw_head_err;
        bvalid_d     = bvalid_q;
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        if (aw_pop) begin
            bvalid_d = 1'b1;
            bid_d    = aw_head_id;
            bresp_d  = aw_head_err ? RESP_SLVERR : RESP_OKAY;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    assign core_in_valid = fwd;
    assign core_in_data  = fwd ? S_AXI_WDATA : '0;

    always_comb begin
        state_d  = state_q;
        rid_d    = rid_q;
        rlen_d   = rlen_q;
        rerr_d   = rerr_q;
        rcnt_d   = rcnt_q;
        ar_pop   = 1'b0;
        in_burst = (state_q == R_BURST);
        r_hs     = S_AXI_RVALID && S_AXI_RREADY;
        case (state_q)
            R_IDLE: begin
                if (!ar_empty) begin
                    ar_pop  = 1'b1;
                    state_d = R_BURST;
                    rid_d   = ar_dout[WIDTH_SID+8:9];
                    rlen_d  = ar_dout[8:1];
                    rerr_d  = ar_dout[0];
                    rcnt_d  = '0;
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    rcnt_d = rcnt_q + 8'd1;
                    if (S_AXI_RLAST) state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign S_AXI_RVALID   = in_burst && (rerr_q || core_out_valid);
    assign S_AXI_RLAST    = in_burst && (rcnt_q == rlen_q);
    assign S_AXI_RDATA    = (in_burst && !rerr_q) ? core_out_data : '0;
    assign S_AXI_RRESP    = (in_burst && rerr_q) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RID      = rid_q;
    assign core_out_ready = in_burst && !rerr_q && S_AXI_RREADY;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            clr_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= RESP_OKAY;
            state_q  <= R_IDLE;
            rid_q    <= '0;
            rlen_q   <= '0;
            rerr_q   <= 1'b0;
            rcnt_q   <= '0;
        end else begin
            clr_q    <= clr_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            state_q  <= state_d;
            rid_q    <= rid_d;
            rlen_q   <= rlen_d;
            rerr_q   <= rerr_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign core_clr     = clr_q;
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BID    = bid_q;
    assign S_AXI_BRESP  = bresp_q;

endmodule

// File: tb/tb_axi_slave_burst_ps.sv
// Directed and randomized bench for axi_slave_burst_ps; a queue-based model predicts core_in words,
// B responses, R beats and clear pulses from the transactions issued.
module tb_axi_slave_burst_ps;

    localparam logic [31:0] CLR = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] S_AXI_AWID = '0, S_AXI_ARID = '0;
    logic [13:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
    logic [2:0]  S_AXI_AWSIZE = 3'd2, S_AXI_ARSIZE = 3'd2;
    logic [1:0]  S_AXI_AWBURST = 2'b01, S_AXI_ARBURST = 2'b01;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '1;
    logic        S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0;
    logic        S_AXI_BREADY = 1'b0, S_AXI_RREADY = 1'b0;
    logic        core_in_ready = 1'b0, core_out_valid = 1'b0;
    logic [31:0] core_out_data = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RLAST, core_clr, core_in_valid, core_out_ready;
    logic [14:0] S_AXI_BID, S_AXI_RID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA, core_in_data;

    axi_slave_burst_ps dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .core_clr(core_clr),
        .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [31:0] exp_in [$];
    logic [16:0] exp_b [$];
    logic [49:0] exp_r [$];
    logic [31:0] src [$];
    logic [31:0] pool [$];
    int clr_pulses = 0, exp_clr = 0, w_hs_cnt = 0, r_hs_cnt = 0;
    int in_mode = 0, b_mode = 0, r_mode = 0, r_stall_at = 0, r_stall_left = 0;
    logic        r_stalled = 1'b0;
    logic [49:0] stall_snap = '0, obs_r;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, S_AXI_ARREADY,
                  S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, core_clr,
                  core_in_valid, core_in_data, core_out_ready}, '0);
    endtask

    // Ready/valid drivers for the core and response channels, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (in_mode)
            0: core_in_ready = 1'b1;
            1: core_in_ready = ~core_in_ready;
            2: core_in_ready = 1'($urandom_range(1));
            default: core_in_ready = 1'b0;
        endcase
        S_AXI_BREADY = (b_mode == 0) ? 1'b1 : (b_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        case (r_mode)
            0: S_AXI_RREADY = 1'b1;
            1: S_AXI_RREADY = 1'($urandom_range(1));
            default: begin
                S_AXI_RREADY = !(r_hs_cnt == r_stall_at && r_stall_left > 0);
                if (!S_AXI_RREADY) r_stall_left--;
            end
        endcase
        core_out_valid = (src.size() != 0);
        core_out_data  = (src.size() != 0) ? src[0] : '0;
    end

    // Scoreboard: every handshake is compared against the model queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_clr) clr_pulses++;
            if (S_AXI_WVALID && S_AXI_WREADY) w_hs_cnt++;
            if (core_in_valid && core_in_ready) begin
                chk("core_in_expected", exp_in.size() != 0, 1);
                if (exp_in.size() != 0) chk("core_in_data", core_in_data, exp_in.pop_front());
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                chk("b_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) chk("b_id_resp", {S_AXI_BID, S_AXI_BRESP}, exp_b.pop_front());
            end
            obs_r = {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};
            if (r_stalled) begin
                chk("r_hold_valid", S_AXI_RVALID, 1);
                chk("r_hold_beat", obs_r, stall_snap);
            end
            if (S_AXI_RVALID && exp_r.size() != 0 && exp_r[0][2:1] == 2'b10)
                chk("err_core_out_ready", core_out_ready, 0);
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                r_hs_cnt++;
                chk("r_expected", exp_r.size() != 0, 1);
                if (exp_r.size() != 0) chk("r_beat", obs_r, exp_r.pop_front());
            end
            r_stalled  = S_AXI_RVALID && !S_AXI_RREADY;
            stall_snap = obs_r;
            if (core_out_valid && core_out_ready && src.size() != 0) void'(src.pop_front());
        end else begin
            r_stalled = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [14:0] id, input logic [1:0] burst, input int len, output bit ok);
        bit hs = 1'b0;
        S_AXI_AWID = id; S_AXI_AWBURST = burst; S_AXI_AWLEN = 8'(len);
        S_AXI_AWADDR = 14'($urandom); S_AXI_AWVALID = 1'b1;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = S_AXI_AWREADY;
            tick();
        end
        S_AXI_AWVALID = 1'b0;
        ok = hs;
    endtask

    task automatic do_write(input logic [14:0] id, input logic [1:0] burst, input logic [31:0] d[$],
                            input bit follow);
        bit ok;
        bit hs;
        exp_b.push_back({id, (burst == 2'b01) ? 2'b00 : 2'b10});
        foreach (d[i]) begin
            if (burst == 2'b01) begin
                if (d[i] == CLR) exp_clr++;
                else exp_in.push_back(d[i]);
            end
        end
        send_aw(id, burst, d.size() - 1, ok);
        chk("aw_accept", ok, 1);
        for (int i = 0; i < d.size(); i++) begin
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = d[i]; S_AXI_WLAST = (i == d.size() - 1);
            hs = 1'b0;
            for (int t = 0; t < 200 && !hs; t++) begin
                @(negedge clk);
                if (follow) chk("wready_follows_ready", S_AXI_WREADY, core_in_ready);
                hs = S_AXI_WREADY;
                tick();
            end
            chk("w_accept", hs, 1);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    endtask

    task automatic do_read(input logic [14:0] id, input logic [1:0] burst, input int len);
        bit hs = 1'b0;
        logic [31:0] w;
        for (int i = 0; i <= len; i++) begin
            if (burst == 2'b01) begin
                if (pool.size() == 0) begin
                    w = $urandom;
                    src.push_back(w);
                    pool.push_back(w);
                end
                w = pool.pop_front();
                exp_r.push_back({id, w, 2'b00, i == len});
            end else begin
                exp_r.push_back({id, 32'h0, 2'b10, i == len});
            end
        end
        S_AXI_ARID = id; S_AXI_ARBURST = burst; S_AXI_ARLEN = 8'(len);
        S_AXI_ARADDR = 14'($urandom); S_AXI_ARVALID = 1'b1;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = S_AXI_ARREADY;
            tick();
        end
        S_AXI_ARVALID = 1'b0;
        chk("ar_accept", hs, 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0 || exp_in.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        chk("drain_in_time", t < 3000, 1);
    endtask

    function automatic logic [31:0] rnd_word();
        return $urandom & 32'h7FFF_FFFE;
    endfunction

    initial begin
        logic [31:0] d [$];
        bit ok;
        int base;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("awready_during_release", {S_AXI_AWREADY, S_AXI_ARREADY}, 2'b00);
        @(negedge clk);
        chk("awready_after_release", {S_AXI_AWREADY, S_AXI_ARREADY}, 2'b11);
        tick();

        // Plain 8-beat INCR write, core always ready.
        d.delete();
        for (int i = 0; i < 8; i++) d.push_back(rnd_word());
        base = w_hs_cnt;
        do_write(15'd3, 2'b01, d, 1'b1);
        @(negedge clk);
        chk("b_after_wlast", {S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP}, {1'b1, 15'd3, 2'b00});
        chk("w_beats_accepted", w_hs_cnt - base, 8);
        tick();
        drain();

        // Same burst with core_in_ready toggling every cycle.
        in_mode = 1;
        tick();
        d.delete();
        for (int i = 0; i < 8; i++) d.push_back(rnd_word());
        do_write(15'd3, 2'b01, d, 1'b1);
        drain();

        // Clear word: consumed even with core_in_ready low, single-cycle pulse.
        in_mode = 3;
        tick();
        tick();
        exp_b.push_back({15'd7, 2'b00});
        exp_clr++;
        send_aw(15'd7, 2'b01, 0, ok);
        chk("clr_aw_accept", ok, 1);
        S_AXI_WVALID = 1'b1; S_AXI_WDATA = CLR; S_AXI_WLAST = 1'b1;
        @(negedge clk);
        chk("clr_wready", S_AXI_WREADY, 1);
        chk("clr_not_forwarded", core_in_valid, 0);
        chk("clr_not_yet", core_clr, 0);
        tick();
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        @(negedge clk);
        chk("clr_pulse", core_clr, 1);
        chk("clr_b", {S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP}, {1'b1, 15'd7, 2'b00});
        tick();
        @(negedge clk);
        chk("clr_pulse_ends", core_clr, 0);
        tick();
        drain();
        in_mode = 0;

        // Read burst with the second beat stalled for three cycles.
        r_mode = 2;
        r_stall_at = r_hs_cnt + 1;
        r_stall_left = 3;
        do_read(15'd5, 2'b01, 3);
        drain();
        chk("stall_applied", r_stall_left, 0);
        r_mode = 0;

        // Non-INCR read returns SLVERR zeros without touching core_out; queued words feed the next read.
        for (int i = 0; i < 2; i++) begin
            d[0] = $urandom;
            src.push_back(d[0]);
            pool.push_back(d[0]);
        end
        do_read(15'd6, 2'b10, 1);
        drain();
        do_read(15'd6, 2'b01, 1);
        drain();
        d.delete();
        for (int i = 0; i < 3; i++) d.push_back(rnd_word());
        do_write(15'd9, 2'b10, d, 1'b0);
        drain();

        // Randomized mix of reads and writes with random backpressure everywhere.
        in_mode = 2; b_mode = 1; r_mode = 1;
        for (int k = 0; k < 24; k++) begin
            logic [1:0] burst;
            int len;
            burst = ($urandom_range(4) == 0) ? 2'($urandom_range(1) * 2) : 2'b01;
            len = $urandom_range(7);
            if ($urandom_range(1) == 0) begin
                d.delete();
                for (int i = 0; i <= len; i++)
                    d.push_back((burst == 2'b01 && $urandom_range(5) == 0) ? CLR : rnd_word());
                do_write(15'($urandom), burst, d, 1'b0);
            end else begin
                do_read(15'($urandom), burst, len);
            end
        end
        drain();
        repeat (3) tick();
        chk("clr_pulse_count", clr_pulses, exp_clr);
        in_mode = 0; b_mode = 2; r_mode = 0;
        tick();

        // Fill the AW queue with BREADY low, then reset in the middle of a burst.
        for (int i = 0; i < 4; i++) begin
            send_aw(15'(i + 1), 2'b01, 3, ok);
            chk("fill_aw_accept", ok, 1);
        end
        @(negedge clk);
        chk("aw_full", S_AXI_AWREADY, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            d[0] = rnd_word();
            exp_in.push_back(d[0]);
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = d[0]; S_AXI_WLAST = 1'b0;
            @(negedge clk);
            chk("mid_burst_wready", S_AXI_WREADY, 1);
            tick();
        end
        S_AXI_WVALID = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        S_AXI_WVALID = 1'b1;
        #1;
        chk_all_zero("async_reset_outputs");
        chk("mid_burst_beats_seen", exp_in.size(), 0);
        exp_in.delete(); exp_b.delete(); exp_r.delete(); src.delete(); pool.delete();
        tick();
        S_AXI_WVALID = 1'b0;
        b_mode = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("awready_low_after_reset", S_AXI_AWREADY, 0);
        @(negedge clk);
        chk("awready_high_after_reset", {S_AXI_AWREADY, S_AXI_BVALID}, 2'b10);
        tick();

        d.delete();
        for (int i = 0; i < 2; i++) d.push_back(rnd_word());
        do_write(15'd11, 2'b01, d, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
